sample_sched: RTL

Sample scheduler for the correlator. Takes the live register-map values driven by the BytePipe register block and produces the sample strobe and the window boundaries. It also produces a result handshake that tells the packet writer when a window has completed. It sits between the register block and the sampling/correlation datapath and is the only block that decides when samples are taken.

---
 rtl/correlator_pkg.sv | 39 +++
 rtl/sched_lfsr.sv | 44 ++++
 rtl/sample_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/correlator_pkg.sv
// correlator_pkg
// Shared definitions for the correlator sampling path: register-field widths,
// enums for window shape and sample mode, the sample scheduler state type,
// the LFSR constants and a small clamping helper used on register fields.
// Optional feature macro used by the consumers of this package:
//   SAMPLE_SCHED_JITTER_EN
package correlator_pkg;

    // Register-field widths for the default correlator configuration
    // (PRECISION = 20, MAX_SAMPLE_RATE_NEGEXP = 15, MAX_SAMPLE_JITTER_NEGEXP = 14).
    localparam int WINDOW_LENGTH_EXP_W    = $clog2(20);
    localparam int SAMPLE_RATE_NEGEXP_W   = $clog2(15);
    localparam int SAMPLE_JITTER_NEGEXP_W = $clog2(14);

    // 16-bit Galois LFSR: right-shifting form, taps for x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        RECTANGULAR = 1'b0,
        LOGDROP     = 1'b1
    } windowShape_t;

    typedef enum logic {
        NONJITTER   = 1'b0,
        NONPERIODIC = 1'b1
    } sampleMode_t;

    typedef enum logic {
        RESTART = 1'b0,
        RUN     = 1'b1
    } schedState_t;

    // Limit a register exponent to the largest value the hardware supports.
    function automatic int clampExp(input int value, input int limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/sched_lfsr.sv
// sched_lfsr
// 16-bit Galois LFSR that supplies the pseudo-random jitter for the sample
// scheduler. It steps once per cycle in which i_advance is high while the
// clock gate is open, and returns to the fixed seed on reset.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset (loads LFSR_SEED)
//   i_cg       clock-gate enable; state holds while low
//   i_advance  step the LFSR this cycle
//   o_value    low OUT_W bits of the LFSR state
module sched_lfsr
    import correlator_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_advance,
    output logic [OUT_W-1:0] o_value
);

    logic [15:0] state_q, state_d;

    // One Galois step: shift right and fold the taps in when a one falls out.
    always_comb begin
        state_d = state_q;
        if (i_cg && i_advance) begin
            state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // State register with synchronous reset to the seed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_value = state_q[OUT_W-1:0];

endmodule

// File: rtl/sample_sched.sv
// sample_sched
// Decides when the correlator takes samples. From the live register-map
// fields it produces the sample strobe, marks the last sample of each window
// and raises a result handshake toward the packet writer. Results that
// complete while the previous one is still unclaimed are counted as dropped.
// Optional feature: SAMPLE_SCHED_JITTER_EN adds the LFSR and NONPERIODIC
// (jittered) intervals; without it mode and jitter inputs are ignored.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cg                         clock-gate enable; low freezes everything
//   i_reg_windowLengthExp        W: window = 2^W samples (clamped to PRECISION)
//   i_reg_sampleRateNegExp       R: nominal interval = 2^R cycles
//   i_reg_sampleMode             0 = NONJITTER, 1 = NONPERIODIC
//   i_reg_sampleJitterNegExp     J: jitter exponent
//   o_sampleStrobe               take a sample this cycle
//   o_windowEnd                  this strobe closes the window
//   o_rslt_valid / i_rslt_ready  completed-window handshake
//   o_dropCount                  saturating count of dropped windows
module sample_sched
    import correlator_pkg::*;
#(
    parameter int PRECISION                = 20,
    parameter int MAX_SAMPLE_RATE_NEGEXP   = 15,
    parameter int MAX_SAMPLE_JITTER_NEGEXP = 14
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_cg,
    input  logic [$clog2(PRECISION)-1:0]                i_reg_windowLengthExp,
    input  logic [$clog2(MAX_SAMPLE_RATE_NEGEXP)-1:0]   i_reg_sampleRateNegExp,
    input  logic                                        i_reg_sampleMode,
    input  logic [$clog2(MAX_SAMPLE_JITTER_NEGEXP)-1:0] i_reg_sampleJitterNegExp,
    output logic                                        o_sampleStrobe,
    output logic                                        o_windowEnd,
    output logic                                        o_rslt_valid,
    input  logic                                        i_rslt_ready,
    output logic [7:0]                                  o_dropCount
);

    localparam int WL_W  = $clog2(PRECISION);
    localparam int SR_W  = $clog2(MAX_SAMPLE_RATE_NEGEXP);
    localparam int CNT_W = MAX_SAMPLE_RATE_NEGEXP;

    schedState_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PRECISION-1:0] wcnt_q, wcnt_d;
    logic [SR_W-1:0]      rateSnap_q, rateSnap_d;
    logic [WL_W-1:0]      winSnap_q, winSnap_d;
    logic                 rsltValid_q, rsltValid_d;
    logic [7:0]           dropCount_q, dropCount_d;

    logic [SR_W-1:0]      rateSel;
    logic [WL_W-1:0]      winSel;
    logic                 cfgChange;
    logic [CNT_W-1:0]     intervalBase;
    logic [CNT_W-1:0]     reload;
    logic [PRECISION-1:0] windowLast;
    logic                 strobe;
    logic                 windowEnd;
    int                   rateEff;
    int                   winEff;

`ifdef SAMPLE_SCHED_JITTER_EN
    localparam int SJ_W = $clog2(MAX_SAMPLE_JITTER_NEGEXP);

    logic             modeSnap_q, modeSnap_d;
    logic [SJ_W-1:0]  jitSnap_q, jitSnap_d;
    logic             modeSel;
    logic [SJ_W-1:0]  jitSel;
    logic [CNT_W-1:0] lfsrValue;
    logic [CNT_W-1:0] jitMask;
    int               jitEff;

    sched_lfsr #(
        .OUT_W     (CNT_W)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_cg      (i_cg),
        .i_advance (strobe),
        .o_value   (lfsrValue)
    );
`else
    logic unusedJitterCfg;
    assign unusedJitterCfg = ^{i_reg_sampleMode, i_reg_sampleJitterNegExp};
`endif

    // In RESTART the live fields are about to become the snapshot, so the
    // first reload must already use them; in RUN the snapshot governs.
    always_comb begin
        rateSel = rateSnap_q;
        winSel  = winSnap_q;
`ifdef SAMPLE_SCHED_JITTER_EN
        modeSel = modeSnap_q;
        jitSel  = jitSnap_q;
`endif
        if (state_q == RESTART) begin
            rateSel = i_reg_sampleRateNegExp;
            winSel  = i_reg_windowLengthExp;
`ifdef SAMPLE_SCHED_JITTER_EN
            modeSel = i_reg_sampleMode;
            jitSel  = i_reg_sampleJitterNegExp;
`endif
        end
    end

    // Any difference between live fields and the snapshot forces a restart.
    always_comb begin
        cfgChange = (i_reg_sampleRateNegExp != rateSnap_q) ||
                    (i_reg_windowLengthExp != winSnap_q);
`ifdef SAMPLE_SCHED_JITTER_EN
        cfgChange = cfgChange ||
                    (i_reg_sampleMode != modeSnap_q) ||
                    (i_reg_sampleJitterNegExp != jitSnap_q);
`endif
    end

    // Masks of the form 2^n - 1 are built bit by bit so no intermediate
    // value is wider than the counter it feeds. The jitter mask is
    // 2^(R'-J'-1) - 1, which collapses to zero when J'+1 > R'.
    always_comb begin
        rateEff      = clampExp(int'(rateSel), MAX_SAMPLE_RATE_NEGEXP);
        winEff       = clampExp(int'(winSel), PRECISION);
        intervalBase = '0;
        windowLast   = '0;
        for (int i = 0; i < CNT_W; i++) begin
            intervalBase[i] = (i < rateEff);
        end
        for (int i = 0; i < PRECISION; i++) begin
            windowLast[i] = (i < winEff);
        end
        reload = intervalBase;
`ifdef SAMPLE_SCHED_JITTER_EN
        jitEff  = clampExp(int'(jitSel), MAX_SAMPLE_JITTER_NEGEXP);
        jitMask = '0;
        if (modeSel == NONPERIODIC) begin
            for (int i = 0; i < CNT_W; i++) begin
                jitMask[i] = (i < (rateEff - jitEff - 1));
            end
        end
        reload = intervalBase - (lfsrValue & jitMask);
`endif
    end

    // A strobe in the same cycle as a config change would belong to the
    // discarded window, so it is suppressed.
    assign strobe    = i_cg && (state_q == RUN) && (cnt_q == '0) && !cfgChange;
    assign windowEnd = strobe && (wcnt_q == windowLast);

    // Scheduler FSM: next state, interval counter, window counter, snapshot.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        rateSnap_d = rateSnap_q;
        winSnap_d  = winSnap_q;
`ifdef SAMPLE_SCHED_JITTER_EN
        modeSnap_d = modeSnap_q;
        jitSnap_d  = jitSnap_q;
`endif
        if (i_cg) begin
            case (state_q)
                RESTART: begin
                    cnt_d      = reload;
                    wcnt_d     = '0;
                    rateSnap_d = i_reg_sampleRateNegExp;
                    winSnap_d  = i_reg_windowLengthExp;
`ifdef SAMPLE_SCHED_JITTER_EN
                    modeSnap_d = i_reg_sampleMode;
                    jitSnap_d  = i_reg_sampleJitterNegExp;
`endif
                    state_d    = RUN;
                end
                RUN: begin
                    if (cfgChange) begin
                        state_d = RESTART;
                    end else if (strobe) begin
                        cnt_d  = reload;
                        wcnt_d = windowEnd ? '0 : wcnt_q + PRECISION'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = RESTART;
            endcase
        end
    end

    // Result handshake: a finished window claims the slot; if the slot was
    // still unclaimed the older result is lost and counted.
    always_comb begin
        rsltValid_d = rsltValid_q;
        dropCount_d = dropCount_q;
        if (i_cg) begin
            if (windowEnd) begin
                rsltValid_d = 1'b1;
                if (rsltValid_q && !i_rslt_ready && (dropCount_q != 8'hFF)) begin
                    dropCount_d = dropCount_q + 8'd1;
                end
            end else if (rsltValid_q && i_rslt_ready) begin
                rsltValid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RESTART;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            rateSnap_q  <= '0;
            winSnap_q   <= '0;
            rsltValid_q <= 1'b0;
            dropCount_q <= 8'd0;
`ifdef SAMPLE_SCHED_JITTER_EN
            modeSnap_q  <= 1'b0;
            jitSnap_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            rateSnap_q  <= rateSnap_d;
            winSnap_q   <= winSnap_d;
            rsltValid_q <= rsltValid_d;
            dropCount_q <= dropCount_d;
`ifdef SAMPLE_SCHED_JITTER_EN
            modeSnap_q  <= modeSnap_d;
            jitSnap_q   <= jitSnap_d;
`endif
        end
    end

    assign o_sampleStrobe = strobe;
    assign o_windowEnd    = windowEnd;
    assign o_rslt_valid   = rsltValid_q;
    assign o_dropCount    = dropCount_q;

endmodule
